// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU/DMA memory bus: owner encoding, burst limits
// and the per-port request bundle.
package cpu_bus_pkg;

   localparam int MAX_BURST_DEF = 4;
   localparam int CNT_W         = 4;
   localparam int AW            = 16;
   localparam int DW            = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_OWN0 = 2'b01,
      ST_OWN1 = 2'b10
   } state_e;

   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_e;

   typedef struct packed {
      logic          req;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } port_req_t;

   function automatic state_e own_state(input port_e p);
      return (p == PORT1) ? ST_OWN1 : ST_OWN0;
   endfunction

   function automatic port_e other_port(input port_e p);
      return (p == PORT1) ? PORT0 : PORT1;
   endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Two-port (CPU/DMA) arbiter for one shared synchronous RAM with bounded
// bursts, registered grants and tagged read-data return.
module bus_arbiter
   import cpu_bus_pkg::*;
#(
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wdata,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_wdata,
   output logic          p0_gnt,
   output logic          p1_gnt,
   output logic [DW-1:0] p0_rdata,
   output logic [DW-1:0] p1_rdata,
   output logic          p0_rvalid,
   output logic          p1_rvalid,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output logic [1:0]    owner
);

   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   port_e            last_q, last_d;
   port_e            own_port;
   logic             gnt0_q, gnt1_q;
   logic             rd_pend_q, rd_pend_d;
   port_e            rd_port_q;
   logic [DW-1:0]    rdata0_q, rdata1_q;
   port_req_t        p0_r, p1_r, own_r, oth_r;
   logic             xfer;

   assign p0_r = '{req: p0_req, we: p0_we, addr: p0_addr, wdata: p0_wdata};
   assign p1_r = '{req: p1_req, we: p1_we, addr: p1_addr, wdata: p1_wdata};

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      own_r    = '0;
      oth_r    = '0;
      own_port = PORT0;
      case (state_q)
         ST_OWN0: begin
            own_r = p0_r;
            oth_r = p1_r;
         end
         ST_OWN1: begin
            own_r    = p1_r;
            oth_r    = p0_r;
            own_port = PORT1;
         end
         default: ;
      endcase
   end

   assign xfer      = own_r.req & (gnt0_q | gnt1_q);
   assign mem_addr  = own_r.addr;
   assign mem_wdata = own_r.wdata;
   assign mem_we    = own_r.we & xfer;
   assign rd_pend_d = xfer & ~own_r.we;

   assign cnt_inc = (cnt_q >= BURST_MAX) ? BURST_MAX : cnt_q + 4'd1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (p0_req && p1_req) state_d = own_state(other_port(last_q));
            else if (p0_req)      state_d = ST_OWN0;
            else if (p1_req)      state_d = ST_OWN1;
         end
         ST_OWN0, ST_OWN1: begin
            if (!own_r.req)
               state_d = oth_r.req ? own_state(other_port(own_port)) : ST_IDLE;
            else if (oth_r.req && cnt_inc >= BURST_MAX)
               state_d = own_state(other_port(own_port));
            else
               cnt_d = cnt_inc;
         end
         default: state_d = ST_IDLE;
      endcase
      // Any change of owner restarts the burst count.
      if (state_d != state_q) begin
         cnt_d = '0;
         if (state_d == ST_OWN0)      last_d = PORT0;
         else if (state_d == ST_OWN1) last_d = PORT1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         last_q    <= PORT1;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         rd_pend_q <= 1'b0;
         rd_port_q <= PORT0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         gnt0_q    <= (state_d == ST_OWN0);
         gnt1_q    <= (state_d == ST_OWN1);
         rd_pend_q <= rd_pend_d;
         rd_port_q <= own_port;
         if (p0_rvalid) rdata0_q <= mem_rdata;
         if (p1_rvalid) rdata1_q <= mem_rdata;
      end
   end

   // The read tag, not the current owner, steers returning data.
   assign p0_rvalid = rd_pend_q & (rd_port_q == PORT0);
   assign p1_rvalid = rd_pend_q & (rd_port_q == PORT1);
   assign p0_rdata  = p0_rvalid ? mem_rdata : rdata0_q;
   assign p1_rdata  = p1_rvalid ? mem_rdata : rdata1_q;

   assign p0_gnt = gnt0_q;
   assign p1_gnt = gnt1_q;
   assign owner  = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: RAM model, per-port request queues and a
// read-data scoreboard checked cycle-exactly.
module tb_bus_arbiter;

   localparam int MB = 4;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we;
   logic [15:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  owner;

   bus_arbiter #(.MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
      .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
      .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .owner(owner)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] pat(input logic [15:0] a);
      return a ^ 16'h5A3C;
   endfunction

   // Synchronous RAM: unwritten words return a fixed address pattern.
   logic [15:0] ram    [0:255];
   logic        ram_wr [0:255];
   logic        ram_clr;
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 256; i++) ram_wr[i] <= 1'b0;
      end else if (mem_we) begin
         ram[mem_addr[7:0]]    <= mem_wdata;
         ram_wr[mem_addr[7:0]] <= 1'b1;
      end
      mem_rdata <= ram_wr[mem_addr[7:0]] ? ram[mem_addr[7:0]] : pat(mem_addr);
   end

   txn_t        q0[$], q1[$];
   logic [15:0] sb0[$], sb1[$];
   logic [15:0] ref_mem [int];
   bit          pend [2];
   int          xfer_cnt [2];
   int          wait_cnt [2];
   int          last_wait [2];
   int          rv_cnt [2];
   int          grant_log[$];
   int          n_cmp, n_bad, cyc, cross_rv, first_cyc0, last_cyc0;
   logic        p1_gnt_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic txn_t mk(input logic we, input int addr, input logic [15:0] wd);
      txn_t t;
      t.we    = we;
      t.addr  = addr[15:0];
      t.wdata = wd;
      return t;
   endfunction

   function automatic logic [15:0] ref_read(input logic [15:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
   endfunction

   task automatic drive_inputs();
      p0_req = (q0.size() != 0); p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
      p1_req = (q1.size() != 0); p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
      if (q0.size() != 0) begin
         p0_we = q0[0].we; p0_addr = q0[0].addr; p0_wdata = q0[0].wdata;
      end
      if (q1.size() != 0) begin
         p1_we = q1[0].we; p1_addr = q1[0].addr; p1_wdata = q1[0].wdata;
      end
   endtask

   task automatic record(input int p);
      txn_t t;
      if (p == 0) t = q0.pop_front();
      else        t = q1.pop_front();
      check($sformatf("p%0d_mem_addr", p), mem_addr, t.addr);
      check($sformatf("p%0d_mem_we", p), mem_we, t.we);
      if (t.we) begin
         check($sformatf("p%0d_mem_wdata", p), mem_wdata, t.wdata);
         ref_mem[int'(t.addr)] = t.wdata;
      end else begin
         if (p == 0) sb0.push_back(ref_read(t.addr));
         else        sb1.push_back(ref_read(t.addr));
         pend[p] = 1'b1;
      end
      grant_log.push_back(p);
      xfer_cnt[p]++;
      if (p == 0) begin
         if (first_cyc0 < 0) first_cyc0 = cyc;
         last_cyc0 = cyc;
      end
   endtask

   task automatic check_rv(input int p);
      logic        rv;
      logic [15:0] rd, e;
      rv = (p == 0) ? p0_rvalid : p1_rvalid;
      rd = (p == 0) ? p0_rdata : p1_rdata;
      if (rv) rv_cnt[p]++;
      if (pend[p]) begin
         if (p == 0) e = sb0.pop_front();
         else        e = sb1.pop_front();
         check($sformatf("p%0d_rvalid", p), rv, 1);
         check($sformatf("p%0d_rdata", p), rd, e);
         if (p == 0 && p1_gnt) cross_rv++;
         pend[p] = 1'b0;
      end else begin
         check($sformatf("p%0d_rvalid_quiet", p), rv, 0);
      end
   endtask

   task automatic port_mon(input int p, input logic req, input logic gnt);
      if (req && !gnt) wait_cnt[p]++;
      else if (req && gnt) begin
         check($sformatf("p%0d_starve", p), wait_cnt[p] <= MB + 1, 1);
         last_wait[p] = wait_cnt[p];
         wait_cnt[p]  = 0;
         record(p);
      end else wait_cnt[p] = 0;
   endtask

   task automatic step_mon();
      @(negedge clk);
      cyc++;
      check_rv(0);
      check_rv(1);
      check("gnt_exclusive", p0_gnt & p1_gnt, 0);
      check("owner_code", owner, {p1_gnt, p0_gnt});
      if (owner == 2'b00) check("idle_bus", {mem_we, mem_addr}, 0);
      p1_gnt_seen |= p1_gnt;
      port_mon(0, p0_req, p0_gnt);
      port_mon(1, p1_req, p1_gnt);
   endtask

   task automatic step_adv();
      @(posedge clk);
      #1;
      drive_inputs();
   endtask

   task automatic step();
      step_mon();
      step_adv();
   endtask

   task automatic run_until_done(input int max_cyc);
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || pend[0] || pend[1]) && n < max_cyc) begin
         step();
         n++;
      end
      check("run_bound", n < max_cyc, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      q0.delete();
      q1.delete();
      drive_inputs();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      sb0.delete();
      sb1.delete();
      grant_log.delete();
      for (int p = 0; p < 2; p++) begin
         pend[p] = 1'b0; xfer_cnt[p] = 0; wait_cnt[p] = 0; last_wait[p] = 0; rv_cnt[p] = 0;
      end
      cross_rv = 0; first_cyc0 = -1; last_cyc0 = -1; p1_gnt_seen = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      n_cmp = 0; n_bad = 0; cyc = 0;
      rst = 1'b1;
      ram_clr = 1'b1;
      drive_inputs();
      #2;
      check("rst_p0_gnt", p0_gnt, 0);
      check("rst_p1_gnt", p1_gnt, 0);
      check("rst_p0_rvalid", p0_rvalid, 0);
      check("rst_p1_rvalid", p1_rvalid, 0);
      check("rst_p0_rdata", p0_rdata, 0);
      check("rst_p1_rdata", p1_rdata, 0);
      check("rst_owner", owner, 0);
      @(posedge clk);
      #1 ram_clr = 1'b0;
      do_reset();
      step();
      step();
      check("idle_owner", owner, 0);

      // Port 0 alone: four reads, grant one cycle after request.
      for (int i = 0; i < 4; i++) q0.push_back(mk(1'b0, 16'h0010 + i, 16'h0));
      drive_inputs();
      n = 0;
      while (xfer_cnt[0] == 0 && n < 10) begin step(); n++; end
      check("p0_grant_latency", last_wait[0], 1);
      run_until_done(20);
      check("p0_solo_xfers", xfer_cnt[0], 4);
      check("p0_solo_rvalids", rv_cnt[0], 4);
      check("p1_gnt_never", p1_gnt_seen, 0);

      // Both ports from reset: 4/4 alternation starting with port 0.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         q0.push_back(mk(1'b0, 16'h0080 + i, 16'h0));
         q1.push_back(mk(1'b0, 16'h0090 + i, 16'h0));
      end
      drive_inputs();
      run_until_done(60);
      check("alt_len", grant_log.size(), 16);
      for (int i = 0; i < 16 && i < grant_log.size(); i++)
         check($sformatf("alt_seq%0d", i), grant_log[i], (i / MB) % 2);

      // Read of 0x00E5 in the last burst cycle returns after the switch.
      do_reset();
      for (int i = 0; i < 4; i++) q0.push_back(mk(1'b0, 16'h00E2 + i, 16'h0));
      for (int i = 0; i < 3; i++) q1.push_back(mk(1'b1, 16'h00A0 + i, 16'h1230 + 16'(i)));
      q1.push_back(mk(1'b0, 16'h00A1, 16'h0));
      drive_inputs();
      run_until_done(40);
      check("e5_switch_a", grant_log[3], 0);
      check("e5_switch_b", grant_log[4], 1);
      check("e5_cross_rvalid", cross_rv > 0, 1);

      // Write from port 1, read back from port 0, data held afterwards.
      q1.push_back(mk(1'b1, 16'h0020, 16'hBEEF));
      drive_inputs();
      run_until_done(20);
      q0.push_back(mk(1'b0, 16'h0020, 16'h0));
      drive_inputs();
      run_until_done(20);
      repeat (3) step();
      check("beef_hold", p0_rdata, 16'hBEEF);

      // Reset with a port-1 read in flight.
      do_reset();
      for (int i = 0; i < 4; i++) q1.push_back(mk(1'b0, 16'h0030 + i, 16'h0));
      drive_inputs();
      n = 0;
      while (n < 20) begin
         step_mon();
         if (xfer_cnt[1] >= 2) break;
         step_adv();
         n++;
      end
      check("mid_read_reached", xfer_cnt[1], 2);
      #2 rst = 1'b1;
      #1;
      check("mrst_p0_gnt", p0_gnt, 0);
      check("mrst_p1_gnt", p1_gnt, 0);
      check("mrst_p0_rvalid", p0_rvalid, 0);
      check("mrst_p1_rvalid", p1_rvalid, 0);
      check("mrst_p1_rdata", p1_rdata, 0);
      check("mrst_owner", owner, 0);
      do_reset();
      repeat (4) step();
      check("mrst_rv_after", rv_cnt[1], 0);
      check("mrst_owner_after", owner, 0);
      q0.push_back(mk(1'b0, 16'h0060, 16'h0));
      q1.push_back(mk(1'b0, 16'h0061, 16'h0));
      drive_inputs();
      run_until_done(20);
      check("mrst_first_winner", grant_log[0], 0);

      // Port 0 streams alone for 20 transfers, then port 1 arrives.
      do_reset();
      for (int i = 0; i < 30; i++) q0.push_back(mk(1'b0, 16'h0040 + i, 16'h0));
      drive_inputs();
      n = 0;
      while (xfer_cnt[0] < 20 && n < 40) begin step(); n++; end
      check("stream_count", xfer_cnt[0], 20);
      check("stream_no_gaps", last_cyc0 - first_cyc0, 19);
      q1.push_back(mk(1'b0, 16'h0050, 16'h0));
      drive_inputs();
      run_until_done(60);
      check("sat_p1_wait", last_wait[1], 1);
      check("sat_seq_a", grant_log[20], 0);
      check("sat_seq_b", grant_log[21], 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
